// File: rtl/argmax_arbiter_if.sv
// Requester-side and max-finder-side signals of the argmax arbiter.
// The arbiter takes the slave view; the environment takes the master view.
interface argmax_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16
);
  localparam int VEC_W = NUM_INPUT * INPUT_WIDTH;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*VEC_W-1:0] req_data;
  logic [NUM_REQ-1:0]       done;
  logic [15:0]              res_data;
  logic                     res_err;
  logic                     busy;
  logic [VEC_W-1:0]         mf_i_data;
  logic                     mf_i_valid;
  logic [15:0]              mf_o_data;
  logic                     mf_o_data_valid;

  modport slave (
    input  req,
    input  req_data,
    input  mf_o_data,
    input  mf_o_data_valid,
    output done,
    output res_data,
    output res_err,
    output busy,
    output mf_i_data,
    output mf_i_valid
  );

  modport master (
    output req,
    output req_data,
    output mf_o_data,
    output mf_o_data_valid,
    input  done,
    input  res_data,
    input  res_err,
    input  busy,
    input  mf_i_data,
    input  mf_i_valid
  );
endinterface

// File: rtl/argmax_arbiter.sv
// Round-robin sharing of one argmax unit between NUM_REQ requesters,
// with a watchdog on the unit's result and registered outputs.
module argmax_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_INPUT   = 10,
  parameter int INPUT_WIDTH = 16,
  parameter int TIMEOUT     = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  argmax_arbiter_if.slave bus
);

  localparam int VEC_W = NUM_INPUT * INPUT_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [15:0]        res_data_q, res_data_d;
  logic               res_err_q, res_err_d;
  logic               busy_q, busy_d;
  logic [VEC_W-1:0]   mfd_q, mfd_d;
  logic               mfv_q, mfv_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [IDX_W-1:0]   cand;
  logic [VEC_W-1:0]   sel_vec;
  logic [NUM_REQ-1:0] grant_oh;

  // First requesting index after the previous winner, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = last_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    sel_vec = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (pick == IDX_W'(r)) begin
        sel_vec = bus.req_data[r*VEC_W +: VEC_W];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      grant_oh[r] = (grant_q == IDX_W'(r));
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    timer_d    = timer_q;
    mfd_d      = mfd_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    mfv_d      = 1'b0;
    done_d     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          mfd_d   = sel_vec;
          mfv_d   = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle beats the watchdog.
        if (bus.mf_o_data_valid) begin
          res_data_d = bus.mf_o_data;
          res_err_d  = 1'b0;
          done_d     = grant_oh;
          state_d    = S_RESP;
        end else if (timer_q == TMR_LAST) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          done_d     = grant_oh;
          state_d    = S_RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_RESP: begin
        last_d    = grant_q;
        res_err_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      last_q     <= LAST_RST;
      timer_q    <= '0;
      done_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      busy_q     <= 1'b0;
      mfd_q      <= '0;
      mfv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      timer_q    <= timer_d;
      done_q     <= done_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      busy_q     <= busy_d;
      mfd_q      <= mfd_d;
      mfv_q      <= mfv_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_err    = res_err_q;
  assign bus.busy       = busy_q;
  assign bus.mf_i_data  = mfd_q;
  assign bus.mf_i_valid = mfv_q;

endmodule

// File: tb/tb_argmax_arbiter.sv
// Randomized scoreboard bench for argmax_arbiter with a behavioural
// max-finder and a round-robin reference model.
module tb_argmax_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int NUM_INPUT   = 10;
  localparam int INPUT_WIDTH = 16;
  localparam int TIMEOUT     = 64;
  localparam int VEC_W       = NUM_INPUT * INPUT_WIDTH;
  localparam int LAT         = NUM_INPUT + 3;
  localparam int PERIOD      = NUM_INPUT + 4;

  typedef struct {
    int who;
    int res;
    bit err;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  int   mf_delay = NUM_INPUT + 1;
  int   mf_force = -1;
  bit   mf_abort;
  int   model_last = NUM_REQ - 1;
  exp_t exp_q[$];
  logic [VEC_W-1:0] vecs [NUM_REQ];

  argmax_arbiter_if #(
    .NUM_REQ(NUM_REQ),
    .NUM_INPUT(NUM_INPUT),
    .INPUT_WIDTH(INPUT_WIDTH)
  ) ifc ();

  argmax_arbiter #(
    .NUM_REQ(NUM_REQ),
    .NUM_INPUT(NUM_INPUT),
    .INPUT_WIDTH(INPUT_WIDTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, logic [VEC_W-1:0] act, logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int argmax_of(logic [VEC_W-1:0] v);
    int best;
    int bestv;
    int s;
    best  = 0;
    bestv = -1;
    for (int k = 0; k < NUM_INPUT; k++) begin
      s = int'(v[k*INPUT_WIDTH +: INPUT_WIDTH]);
      if (s > bestv) begin
        bestv = s;
        best  = k;
      end
    end
    return best;
  endfunction

  function automatic logic [VEC_W-1:0] rand_vec(int hi);
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      v[k*INPUT_WIDTH +: INPUT_WIDTH] = INPUT_WIDTH'($urandom_range(0, hi));
    return v;
  endfunction

  // Behavioural shared max-finder: answers mf_delay cycles after the
  // start pulse, reading the vector at answer time.
  initial begin
    ifc.mf_o_data_valid = 1'b0;
    ifc.mf_o_data       = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.mf_i_valid) begin
        mf_abort = 1'b0;
        for (int k = 0; k < mf_delay && !mf_abort; k++) begin
          @(negedge clk);
          if (!rst_n) mf_abort = 1'b1;
        end
        if (!mf_abort) begin
          if (mf_force >= 0) ifc.mf_o_data = 16'(mf_force);
          else ifc.mf_o_data = 16'(argmax_of(ifc.mf_i_data));
          ifc.mf_o_data_valid = 1'b1;
          @(negedge clk);
          ifc.mf_o_data_valid = 1'b0;
        end
      end
    end
  end

  // Monitor: every done pulse must match the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (|ifc.done)) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_done: got done=%b expected none", ifc.done);
        end else begin
          e = exp_q.pop_front();
          chk("done_vec", ifc.done, NUM_REQ'(1) << e.who);
          chk("res_data", ifc.res_data, 16'(e.res));
          chk("res_err", ifc.res_err, e.err);
          if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    ifc.req = ifc.req & ~ifc.done;
  endtask

  task automatic set_req_data();
    for (int r = 0; r < NUM_REQ; r++)
      ifc.req_data[r*VEC_W +: VEC_W] = vecs[r];
  endtask

  task automatic launch(logic [NUM_REQ-1:0] m, output int c);
    set_req_data();
    ifc.req = m;
    c = cyc;
  endtask

  task automatic push_one(int who, int res, bit err, int c);
    exp_t e;
    e.who = who;
    e.res = res;
    e.err = err;
    e.cyc = c;
    exp_q.push_back(e);
    model_last = who;
  endtask

  // Reference order: walk the requesters starting just after the last
  // winner; each served back to back, one PERIOD apart.
  task automatic push_batch(logic [NUM_REQ-1:0] m, int c);
    int order[$];
    int start;
    start = model_last;
    for (int k = 1; k <= NUM_REQ; k++)
      if (m[(start + k) % NUM_REQ]) order.push_back((start + k) % NUM_REQ);
    foreach (order[i])
      push_one(order[i], argmax_of(vecs[order[i]]), 1'b0, c + LAT + i * PERIOD);
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    step();
  endtask

  initial begin
    int c;
    int s1[NUM_INPUT] = '{3, 9, 2, 7, 9, 1, 0, 4, 8, 5};
    logic [VEC_W-1:0] orig;
    logic [VEC_W-1:0] alt;
    logic [NUM_REQ-1:0] m;
    bit busy_seen;
    int am;

    rst_n        = 1'b0;
    ifc.req      = '0;
    ifc.req_data = '0;
    for (int r = 0; r < NUM_REQ; r++) vecs[r] = '0;
    repeat (3) step();
    chk("rst_done", ifc.done, 0);
    chk("rst_res_data", ifc.res_data, 0);
    chk("rst_res_err", ifc.res_err, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_mf_i_data", ifc.mf_i_data, 0);
    chk("rst_mf_i_valid", ifc.mf_i_valid, 0);
    rst_n = 1'b1;
    step();

    // Round robin from reset, then 0 and 2 after last grant 3.
    for (int r = 0; r < NUM_REQ; r++) vecs[r] = rand_vec(1000);
    launch('1, c);
    push_batch('1, c);
    drain(300);
    vecs[0] = rand_vec(1000);
    vecs[2] = rand_vec(1000);
    launch(4'b0101, c);
    push_batch(4'b0101, c);
    drain(300);

    // Single request with the documented vector: first maximum at 1.
    for (int k = 0; k < NUM_INPUT; k++)
      vecs[0][k*INPUT_WIDTH +: INPUT_WIDTH] = INPUT_WIDTH'(s1[k]);
    launch(4'b0001, c);
    push_one(0, 1, 1'b0, c + LAT);
    step();
    chk("launch_valid", ifc.mf_i_valid, 1);
    chk("launch_data", ifc.mf_i_data, vecs[0]);
    step();
    chk("launch_pulse_end", ifc.mf_i_valid, 0);
    chk("busy_wait", ifc.busy, 1);
    drain(300);

    // Timeout; the late strobe lands in IDLE and must be ignored.
    mf_delay = TIMEOUT + 2;
    vecs[2]  = rand_vec(1000);
    launch(4'b0100, c);
    push_one(2, 0, 1'b1, c + TIMEOUT + 2);
    drain(300);
    busy_seen = 1'b0;
    repeat (8) begin
      step();
      busy_seen = busy_seen | ifc.busy;
    end
    chk("late_strobe_idle", busy_seen, 0);

    // Result on the same cycle the watchdog expires.
    mf_delay = TIMEOUT;
    mf_force = 6;
    vecs[1]  = rand_vec(1000);
    launch(4'b0010, c);
    push_one(1, 6, 1'b0, c + TIMEOUT + 2);
    drain(300);
    mf_force = -1;
    mf_delay = NUM_INPUT + 1;

    // Asynchronous reset in WAIT: no done, priority back to req[0].
    launch(4'b0010, c);
    repeat (4) step();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_done", ifc.done, 0);
    chk("mid_rst_res_data", ifc.res_data, 0);
    chk("mid_rst_res_err", ifc.res_err, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_mf_i_data", ifc.mf_i_data, 0);
    chk("mid_rst_mf_i_valid", ifc.mf_i_valid, 0);
    ifc.req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    model_last = NUM_REQ - 1;
    step();
    vecs[0] = rand_vec(1000);
    vecs[3] = rand_vec(1000);
    launch(4'b1001, c);
    push_batch(4'b1001, c);
    drain(300);

    // Requester data changes after launch must not leak in.
    vecs[3] = rand_vec(1000);
    orig    = vecs[3];
    launch(4'b1000, c);
    push_batch(4'b1000, c);
    step();
    step();
    am  = argmax_of(orig);
    alt = orig;
    alt[((am + 1) % NUM_INPUT)*INPUT_WIDTH +: INPUT_WIDTH] = '1;
    vecs[3] = alt;
    set_req_data();
    step();
    chk("isolation_mf_i_data", ifc.mf_i_data, orig);
    drain(300);

    // Random request masks with small scores to provoke ties.
    for (int t = 0; t < 20; t++) begin
      m = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      for (int r = 0; r < NUM_REQ; r++) vecs[r] = rand_vec(7);
      repeat ($urandom_range(0, 2)) step();
      launch(m, c);
      push_batch(m, c);
      drain(300);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
